trade_order_ctrl: RTL and testbench

Order sequencer between the Z-score signal stage and the order gateway. It converts the registered buy/sell pulses from the Z-score engine into one-at-a-time orders, using a valid/ready issue handshake and a fill/acknowledge phase. It also maintains the net position, enforces a symmetric position limit, applies a post-trade cooldown and counts signals it had to drop. It sits directly downstream of the Z-score stage and is the only block allowed to drive the gateway.

---
 rtl/trade_order_ctrl.sv | 131 +++++++++++++
 tb/tb_trade_order_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trade_order_ctrl.sv
// Order sequencer between the Z-score stage and the order gateway: one order in flight,
// symmetric position limit, ack timeout, post-trade cooldown and a saturating drop counter.
module trade_order_ctrl #(
   parameter int unsigned MAX_POS     = 4,
   parameter int unsigned COOLDOWN    = 8,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_valid_z,
   input  logic        buy_signal,
   input  logic        sell_signal,
   input  logic [7:0]  price_in,
   output logic        order_valid,
   output logic        order_side,
   output logic [7:0]  order_price,
   input  logic        order_ready,
   input  logic        ack_valid,
   input  logic        ack_filled,
   output logic [7:0]  position,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] drop_cnt
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT);
   localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic signed [7:0] PosMax = 8'(MAX_POS);
   localparam logic signed [7:0] PosMin = -PosMax;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StCooldown} state_e;

   state_e                state_q, state_d;
   logic                  side_q, side_d;
   logic [7:0]            price_q, price_d;
   logic signed [7:0]     pos_q, pos_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [CW-1:0]         cool_q, cool_d;
   logic                  tout_q, tout_d;
   logic [15:0]           drop_q, drop_d;
   logic                  req, allowed, drop;

   always_comb begin
      req     = data_valid_z & (buy_signal | sell_signal);
      allowed = (buy_signal ^ sell_signal) &
                (buy_signal ? (pos_q < PosMax) : (pos_q > PosMin));
      state_d = state_q;
      side_d  = side_q;
      price_d = price_q;
      pos_d   = pos_q;
      timer_d = timer_q;
      cool_d  = cool_q;
      tout_d  = 1'b0;
      drop_d  = drop_q;
      drop    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (allowed) begin
                  state_d = StIssue;
                  side_d  = buy_signal;
                  price_d = price_in;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         StIssue: begin
            drop = req;
            if (order_ready) begin
               state_d = StWaitAck;
               timer_d = '0;
            end
         end
         StWaitAck: begin
            drop    = req;
            timer_d = timer_q + 1'b1;
            // An ack in the timeout cycle takes priority over the timeout
            if (ack_valid) begin
               if (ack_filled) pos_d = side_q ? pos_q + 8'sd1 : pos_q - 8'sd1;
               state_d = StCooldown;
               cool_d  = '0;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               tout_d  = 1'b1;
               state_d = StCooldown;
               cool_d  = '0;
            end
         end
         StCooldown: begin
            drop = req;
            if (cool_q == CW'(COOLDOWN - 1)) state_d = StIdle;
            else                             cool_d  = cool_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         side_q  <= 1'b0;
         price_q <= '0;
         pos_q   <= '0;
         timer_q <= '0;
         cool_q  <= '0;
         tout_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         price_q <= price_d;
         pos_q   <= pos_d;
         timer_q <= timer_d;
         cool_q  <= cool_d;
         tout_q  <= tout_d;
         drop_q  <= drop_d;
      end
   end

   assign order_valid = (state_q == StIssue);
   assign busy        = (state_q != StIdle);
   assign order_side  = side_q;
   assign order_price = price_q;
   assign position    = pos_q;
   assign timeout_err = tout_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Bench for trade_order_ctrl: directed scenarios plus random traffic, all checked against a
// timestamp-based model of order lifetime (offer, await ack, cooldown deadline).
module tb_trade_order_ctrl;

   localparam int MaxPos = 3;
   localparam int Cd     = 4;
   localparam int AckTo  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv = 1'b0, buy = 1'b0, sell = 1'b0;
   logic [7:0]  price = '0;
   logic        ready = 1'b0, ackv = 1'b0, ackf = 1'b0;
   logic        order_valid, order_side, busy, timeout_err;
   logic [7:0]  order_price, position;
   logic [15:0] drop_cnt;

   trade_order_ctrl #(
      .MAX_POS     (MaxPos),
      .COOLDOWN    (Cd),
      .ACK_TIMEOUT (AckTo)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_valid_z (dv),
      .buy_signal   (buy),
      .sell_signal  (sell),
      .price_in     (price),
      .order_valid  (order_valid),
      .order_side   (order_side),
      .order_price  (order_price),
      .order_ready  (ready),
      .ack_valid    (ackv),
      .ack_filled   (ackf),
      .position     (position),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int tout_seen = 0;
   int t0;

   // Model: an order is either offered, awaiting ack since handshake cycle m_h, or the
   // block is cooling down until cycle m_cool_end.
   bit m_offer, m_wait, m_tout;
   int m_h, m_cool_end, m_pos, m_drops, m_side, m_price;

   task automatic check(input string tag, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_offer = 0; m_wait = 0; m_tout = 0;
      m_h = 0; m_cool_end = 0; m_pos = 0; m_drops = 0; m_side = 0; m_price = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, int'(order_valid), 0);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_side"},  int'(order_side), 0);
      check({tag, "_price"}, int'(order_price), 0);
      check({tag, "_pos"},   int'(position), 0);
      check({tag, "_tout"},  int'(timeout_err), 0);
      check({tag, "_drop"},  int'(drop_cnt), 0);
   endtask

   task automatic step(input bit v, input bit b, input bit s, input int p,
                       input bit rdy, input bit av, input bit af);
      bit idle;
      bit req;
      dv = v; buy = b; sell = s; price = 8'(p); ready = rdy; ackv = av; ackf = af;
      @(negedge clk);
      idle = !m_offer && !m_wait && (cyc >= m_cool_end);
      check("valid", int'(order_valid), int'(m_offer));
      check("busy",  int'(busy), int'(!idle));
      check("pos",   int'($signed(position)), m_pos);
      check("drop",  int'(drop_cnt), m_drops);
      check("tout",  int'(timeout_err), int'(m_tout));
      if (m_offer) begin
         check("side",  int'(order_side), m_side);
         check("price", int'(order_price), m_price);
      end
      if (timeout_err) tout_seen++;
      req    = v && (b || s);
      m_tout = 0;
      if (idle) begin
         if (req) begin
            if ((b != s) && (b ? (m_pos < MaxPos) : (m_pos > -MaxPos))) begin
               m_offer = 1; m_side = int'(b); m_price = p & 255;
            end else begin
               m_drops++;
            end
         end
      end else begin
         if (req) m_drops++;
         if (m_offer) begin
            if (rdy) begin m_offer = 0; m_wait = 1; m_h = cyc; end
         end else if (m_wait) begin
            if (av) begin
               if (af) m_pos += (m_side != 0) ? 1 : -1;
               m_wait = 0; m_cool_end = cyc + 1 + Cd;
            end else if (cyc == m_h + AckTo) begin
               m_wait = 0; m_tout = 1; m_cool_end = cyc + 1 + Cd;
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Request, immediate ready, immediate ack, then wait out the cooldown.
   task automatic trade(input bit b, input bit filled);
      step(1, b, !b, int'($urandom_range(0, 255)), 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, filled);
      quiet(Cd);
   endtask

   initial begin
      model_reset();
      #12;
      check_zero("rst");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Buy at 0x40, ready and fill immediately
      step(1, 1, 0, 'h40, 0, 0, 0);
      check("t1_valid", int'(order_valid), 1);
      check("t1_side",  int'(order_side), 1);
      check("t1_price", int'(order_price), 'h40);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      check("t1_pos", int'($signed(position)), 1);
      quiet(Cd - 1);
      check("t1_busy_last", int'(busy), 1);
      quiet(1);
      check("t1_busy_done", int'(busy), 0);

      // Position limit: two buys accepted, two dropped
      for (int i = 0; i < 4; i++) trade(1, 1);
      check("lim_pos",  int'($signed(position)), 3);
      check("lim_drop", int'(drop_cnt), 2);

      // Asynchronous reset while waiting for an ack
      step(1, 0, 1, 'h11, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1 check_zero("arst");
      model_reset();
      dv = 0; buy = 0; sell = 0; ready = 0; ackv = 0; ackf = 0;
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      trade(1, 1);
      check("arst_pos", int'($signed(position)), 1);

      // Backpressure for 10 cycles
      step(1, 1, 0, 'h9c, 0, 0, 0);
      quiet(10);
      check("bp_price", int'(order_price), 'h9c);
      step(0, 0, 0, 0, 1, 0, 0);
      check("bp_valid", int'(order_valid), 0);
      step(0, 0, 0, 0, 0, 1, 1);
      quiet(Cd);
      check("bp_pos", int'($signed(position)), 2);

      // Ack timeout; a late ack in cooldown is ignored
      t0 = tout_seen;
      step(1, 0, 1, 'h21, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      quiet(AckTo);
      check("to_pulse", int'(timeout_err), 1);
      step(0, 0, 0, 0, 0, 1, 1);
      quiet(Cd - 1);
      check("to_count", tout_seen - t0, 1);
      check("to_pos", int'($signed(position)), 2);

      // Ack on the exact timeout cycle wins
      t0 = tout_seen;
      step(1, 1, 0, 'h33, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      quiet(AckTo - 1);
      step(0, 0, 0, 0, 0, 1, 1);
      check("col_tout", int'(timeout_err), 0);
      check("col_pos", int'($signed(position)), 3);
      quiet(Cd);
      check("col_count", tout_seen - t0, 0);

      // Buy and sell together, then a request during cooldown
      step(1, 1, 1, 'h44, 0, 0, 0);
      check("both_valid", int'(order_valid), 0);
      check("both_drop", int'(drop_cnt), 1);
      step(1, 0, 1, 'h55, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 'h66, 0, 0, 0);
      quiet(Cd - 1);
      check("cd_drop", int'(drop_cnt), 2);
      check("cd_pos", int'($signed(position)), 3);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
